// File: rtl/cache_access_ctrl.sv
// Sequencing controller for the LRU cache tag array. It arbitrates requesters round-robin,
// runs one lookup at a time, models a fixed-latency refill on a miss and keeps hit/miss stats.
module cache_access_ctrl #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MISS_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       lk_valid,
    output logic [ADDR_W-1:0]          lk_addr,
    input  logic                       lk_hit,
    output logic                       fill_valid,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       resp_hit,
    output logic [31:0]                hit_cnt,
    output logic [31:0]                miss_cnt
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StTag,
        StRefill,
        StFill,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [IdW-1:0]      resp_id_q, resp_id_d;
    logic                resp_hit_q, resp_hit_d;
    logic                lk_valid_q, lk_valid_d;
    logic                fill_valid_q, fill_valid_d;
    logic                resp_valid_q, resp_valid_d;
    logic [7:0]          lat_q, lat_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic                grant_found;
    logic [IdW-1:0]      grant_id;
    logic [IdW-1:0]      rr_idx;

    // Search starts just past the previous winner so every requester is served in turn.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        rr_idx      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_idx = IdW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[rr_idx]) begin
                grant_found = 1'b1;
                grant_id    = rr_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && !rst && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_id;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        resp_id_d    = resp_id_q;
        resp_hit_d   = resp_hit_q;
        lat_d        = lat_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        lk_valid_d   = 1'b0;
        fill_valid_d = 1'b0;
        resp_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d      = StLookup;
                    addr_d       = req_addr[grant_id*ADDR_W +: ADDR_W];
                    resp_id_d    = grant_id;
                    last_grant_d = grant_id;
                    lk_valid_d   = 1'b1;
                end
            end
            StLookup: state_d = StTag;
            StTag: begin
                if (lk_hit) begin
                    hit_cnt_d    = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 32'd1;
                    resp_hit_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 32'd1;
                    resp_hit_d = 1'b0;
                    lat_d      = 8'(MISS_LAT - 1);
                    state_d    = StRefill;
                end
            end
            StRefill: begin
                if (lat_q == 8'd0) begin
                    fill_valid_d = 1'b1;
                    state_d      = StFill;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            StFill: begin
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    addr_d  = '0;
                    state_d = StIdle;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= IdW'(NUM_REQ - 1);
            addr_q       <= '0;
            resp_id_q    <= '0;
            resp_hit_q   <= 1'b0;
            lat_q        <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            lk_valid_q   <= 1'b0;
            fill_valid_q <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            resp_id_q    <= resp_id_d;
            resp_hit_q   <= resp_hit_d;
            lat_q        <= lat_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            lk_valid_q   <= lk_valid_d;
            fill_valid_q <= fill_valid_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign lk_valid   = lk_valid_q;
    assign lk_addr    = addr_q;
    assign fill_valid = fill_valid_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_hit   = resp_hit_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
